mmio_bus_ctrl: RTL and testbench

//  Parametrised, sequential successor to the Hack memory-mapped IO mux.

---
 rtl/mmio_bus_ctrl_if.sv | 39 +++
 rtl/mmio_bus_ctrl.sv | 139 +++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmio_bus_ctrl_if                                                |
// | Brief    : CPU, RAM and device bus signals of the MMIO bus controller      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mmio_bus_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int N_IO   = 16
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic                     cpu_ack;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_err;
  logic                     ram_sel;
  logic                     ram_load;
  logic [DATA_W-1:0]        ram_rdata;
  logic [N_IO-1:0]          dev_sel;
  logic [N_IO-1:0]          dev_load;
  logic [N_IO-1:0]          dev_rdy;
  logic [N_IO*DATA_W-1:0]   dev_rdata;
  logic [DATA_W-1:0]        wdata;

  // master: CPU plus the RAM/device side environment; slave: the controller
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, dev_rdy, dev_rdata,
    input  cpu_ack, cpu_rdata, cpu_err, ram_sel, ram_load, dev_sel, dev_load, wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata, dev_rdy, dev_rdata,
    output cpu_ack, cpu_rdata, cpu_err, ram_sel, ram_load, dev_sel, dev_load, wdata
  );
endinterface
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmio_bus_ctrl                                                   |
// | Brief    : Sequential req/ack MMIO decoder to RAM or N_IO wait-state devs  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mmio_bus_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int IO_BIT  = 13,
  parameter int SEL_W   = 4,
  parameter int N_IO    = 16,
  parameter int RAM_LAT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  mmio_bus_ctrl_if.slave     bus
);

  localparam int             c_CNT_MAX = (TIMEOUT > RAM_LAT) ? TIMEOUT : RAM_LAT;
  localparam int             c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [SEL_W:0] c_N_IO    = (SEL_W+1)'(N_IO);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic                 r_we, r_is_ram, r_is_dev, r_err;
  logic [SEL_W-1:0]     r_ch;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_wdata, r_rdata;

  logic                 w_accept, w_busy, w_rdy, w_exit, w_mapped;
  logic                 w_last_ram, w_expired, w_cap_err, w_unused_addr;
  logic [N_IO-1:0]      w_hit;
  logic [DATA_W-1:0]    w_dev_data, w_cap_rdata;

  assign w_accept      = (r_state == S_IDLE) && bus.cpu_req;
  assign w_busy        = (r_state == S_ACCESS) || (r_state == S_WAIT);
  assign w_mapped      = {1'b0, bus.cpu_addr[SEL_W-1:0]} < c_N_IO;
  assign w_unused_addr = ^bus.cpu_addr;

  generate
    for (genvar k = 0; k < N_IO; k++) begin : g_hit
      assign w_hit[k] = (r_ch == SEL_W'(k));
    end
  endgenerate

  // Only the latched channel's ready and data are observed
  assign w_rdy = |(bus.dev_rdy & w_hit);

  always_comb begin
    w_dev_data = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (w_hit[k]) w_dev_data = bus.dev_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign w_last_ram = (r_cnt == c_CNT_W'(RAM_LAT - 1));
  assign w_expired  = (r_cnt == c_CNT_W'(TIMEOUT - 1));
  assign w_exit     = w_busy && (r_is_ram ? w_last_ram :
                                 r_is_dev ? (w_rdy || w_expired) : 1'b1);

  // Ready on the expiring cycle is checked first, so it beats the timeout
  always_comb begin
    w_cap_rdata = '0;
    w_cap_err   = 1'b0;
    if (r_is_ram) begin
      if (!r_we) w_cap_rdata = bus.ram_rdata;
    end else if (r_is_dev) begin
      if (w_rdy) begin
        if (!r_we) w_cap_rdata = w_dev_data;
      end else begin
        w_cap_err = 1'b1;
      end
    end else begin
      w_cap_err = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:           if (bus.cpu_req) w_next = S_ACCESS;
      S_ACCESS, S_WAIT: w_next = w_exit ? S_DONE : S_WAIT;
      S_DONE:           w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_is_ram <= 1'b0;
      r_is_dev <= 1'b0;
      r_ch     <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= bus.cpu_we;
        r_wdata  <= bus.cpu_wdata;
        r_is_ram <= !bus.cpu_addr[IO_BIT];
        r_is_dev <= bus.cpu_addr[IO_BIT] && w_mapped;
        r_ch     <= bus.cpu_addr[SEL_W-1:0];
        r_cnt    <= '0;
      end else if (w_busy) begin
        r_cnt    <= r_cnt + c_CNT_W'(1);
      end
      if (w_exit) begin
        r_rdata <= w_cap_rdata;
        r_err   <= w_cap_err;
      end
    end
  end

  assign bus.ram_sel   = w_busy && r_is_ram;
  assign bus.ram_load  = (r_state == S_ACCESS) && r_is_ram && r_we;
  assign bus.dev_sel   = {N_IO{w_busy && r_is_dev}} & w_hit;
  assign bus.dev_load  = {N_IO{(r_state == S_ACCESS) && r_is_dev && r_we}} & w_hit;
  assign bus.cpu_ack   = (r_state == S_DONE);
  assign bus.cpu_rdata = (r_state == S_DONE) ? r_rdata : '0;
  assign bus.cpu_err   = (r_state == S_DONE) && r_err;
  assign bus.wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mmio_bus_ctrl                                                |
// | Brief    : Table-driven, scoreboarded bench for mmio_bus_ctrl (N_IO=12)    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mmio_bus_ctrl;
  localparam int c_DATA_W = 16, c_ADDR_W = 16, c_IO_BIT = 13, c_SEL_W = 4;
  localparam int c_N_IO = 12, c_RAM_LAT = 1, c_TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmio_bus_ctrl_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W), .N_IO(c_N_IO)) bus ();

  mmio_bus_ctrl #(
    .DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W), .IO_BIT(c_IO_BIT), .SEL_W(c_SEL_W),
    .N_IO(c_N_IO), .RAM_LAT(c_RAM_LAT), .TIMEOUT(c_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0, n_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          ack_cyc;
    logic [15:0] wdata;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  // Scoreboard side: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.cpu_ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("ack_cycle", cyc, m_e.ack_cyc);
        check("ack_rdata", {16'd0, bus.cpu_rdata}, {16'd0, m_e.rdata});
        check("ack_err", {31'd0, bus.cpu_err}, {31'd0, m_e.err});
        check("wdata_latched", {16'd0, bus.wdata}, {16'd0, m_e.wdata});
      end
    end
  end

  always @(negedge clk) begin
    if ($countones({bus.ram_sel, bus.dev_sel}) > 1 || $countones(bus.dev_load) > 1 ||
        (bus.ram_load && !bus.ram_sel) || ((bus.dev_load & ~bus.dev_sel) != '0))
      n_viol++;
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] data;      // RAM or target-device read data
    int          rdy_dly;   // cycles after ACCESS until target ready, -1 = never
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // ack cycle minus ACCESS cycle
  } vec_t;

  task automatic setup_env(input logic [15:0] addr, input logic [15:0] data);
    logic [3:0] ch;
    ch = addr[3:0];
    bus.ram_rdata = addr[13] ? 16'hDEAD : data;
    for (int k = 0; k < c_N_IO; k++) begin
      bus.dev_rdata[k*16 +: 16] = 16'hD000 | 16'(k);
      bus.dev_rdy[k] = 1'b1;
    end
    if (addr[13] && ch < 4'(c_N_IO)) begin
      bus.dev_rdata[ch*16 +: 16] = data;
      bus.dev_rdy[ch] = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0]  ch;
    logic        is_dev, is_ram;
    logic [11:0] hot;
    int n_rl = 0, n_dl = 0, n_rs = 0, n_ds = 0, n_bad = 0;
    bit done = 0;
    ch     = v.addr[3:0];
    is_ram = !v.addr[13];
    is_dev = v.addr[13] && (ch < 4'(c_N_IO));
    hot    = is_dev ? (12'd1 << ch) : 12'd0;
    @(negedge clk);
    setup_env(v.addr, v.data);
    bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err, cyc + 1 + v.exp_lat, v.wdata});
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_addr = 16'hFFFF; bus.cpu_wdata = ~v.wdata; bus.cpu_we = ~v.we;
    for (int i = 0; i < v.exp_lat + 8 && !done; i++) begin
      if (is_dev && v.rdy_dly >= 0 && i >= v.rdy_dly) bus.dev_rdy[ch] = 1'b1;
      #1;
      n_rl += int'(bus.ram_load);
      n_rs += int'(bus.ram_sel);
      n_dl += int'(bus.dev_load != '0);
      n_ds += int'(bus.dev_sel == hot && hot != '0);
      n_bad += int'((bus.dev_sel & ~hot) != '0);
      if (bus.cpu_ack) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      check("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    check("ram_load_pulses", n_rl, (is_ram && v.we) ? 1 : 0);
    check("ram_sel_cycles", n_rs, is_ram ? c_RAM_LAT : 0);
    check("dev_load_pulses", n_dl, (is_dev && v.we) ? 1 : 0);
    check("dev_sel_cycles", n_ds, is_dev ? v.exp_lat : 0);
    check("stray_dev_sel", n_bad, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack_rdata_err"}, {15'd0, bus.cpu_ack, bus.cpu_rdata}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.cpu_err}, 32'd0);
    check({tag, "_ram"}, {30'd0, bus.ram_sel, bus.ram_load}, 32'd0);
    check({tag, "_dev"}, {8'd0, bus.dev_sel, bus.dev_load}, 32'd0);
    check({tag, "_wdata"}, {16'd0, bus.wdata}, 32'd0);
  endtask

  vec_t vecs[11];
  int   t0;

  initial begin
    vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, -1, 16'h0000, 1'b0, 1};
    vecs[1]  = '{1'b0, 16'h1FFF, 16'h1111, 16'h1234, -1, 16'h1234, 1'b0, 1};
    vecs[2]  = '{1'b0, 16'hC123, 16'h2222, 16'h5A5A, -1, 16'h5A5A, 1'b0, 1};
    vecs[3]  = '{1'b0, 16'h2003, 16'h3333, 16'hA5A5,  5, 16'hA5A5, 1'b0, 6};
    vecs[4]  = '{1'b1, 16'h2007, 16'h4444, 16'h7777, -1, 16'h0000, 1'b1, 64};
    vecs[5]  = '{1'b0, 16'h200C, 16'h5555, 16'h9999, -1, 16'h0000, 1'b1, 1};
    vecs[6]  = '{1'b1, 16'h200F, 16'h6666, 16'h8888, -1, 16'h0000, 1'b1, 1};
    vecs[7]  = '{1'b0, 16'hE00B, 16'h7777, 16'h1357,  0, 16'h1357, 1'b0, 1};
    vecs[8]  = '{1'b0, 16'h2000, 16'h8888, 16'h0F0F, 63, 16'h0F0F, 1'b0, 64};
    vecs[9]  = '{1'b1, 16'h2005, 16'hCAFE, 16'h4321,  2, 16'h0000, 1'b0, 3};
    vecs[10] = '{1'b0, 16'h2010, 16'h9999, 16'h2222,  1, 16'h2222, 1'b0, 2};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ram_rdata = '0; bus.dev_rdy = '0; bus.dev_rdata = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Request held high: one acceptance every third cycle
    @(negedge clk);
    setup_env(16'h200C, 16'h0000);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h200C; bus.cpu_wdata = 16'h0B2B;
    t0 = cyc;
    for (int k = 0; k < 3; k++) sb.push_back('{16'h0000, 1'b1, t0 + 2 + 3*k, 16'h0B2B});
    repeat (8) @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_drained", sb.size(), 0);
    sb.delete();

    // Reset during WAIT aborts the access silently
    @(negedge clk);
    setup_env(16'h2003, 16'hA5A5);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2003; bus.cpu_wdata = 16'h1357;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_dev_sel", {20'd0, bus.dev_sel}, 32'h8);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    bus.dev_rdy[3] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.dev_rdy[3] = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("post_reset");
    run_vec(vecs[3]);

    check("strobe_invariants", n_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
